regfile_multiport: RTL and testbench

Parametrised multi-port register file with write-through bypass, optional hard-wired zero register, and a per-register busy scoreboard for pipeline hazard detection. It sits in the decode stage of the 5-stage pipeline. It takes NWR write-back ports from MEM/WB and a reservation port from issue. It provides NRD combinational read ports, each with a busy flag, so that decode can stall on unresolved producers.

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_wr_arbiter.sv | 46 ++++
 rtl/regfile_multiport.sv | 112 +++++++++++
 tb/tb_regfile_multiport.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and write-port resolution for the register file
`timescale 1ns/1ps
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 4;

  // Upper bounds the resolver is sized for; callers zero-pad into these widths.
  localparam int MAX_NWR     = 8;
  localparam int MAX_ADDR_W  = 16;
  localparam int PORT_IDX_W  = 3;

  typedef struct packed {
    logic                  hit;
    logic [PORT_IDX_W-1:0] idx;
  } wr_sel_t;

  // Finds the highest-indexed enabled write port whose address matches addr.
  // Padded (unused) ports carry en=0 and can never hit.
  function automatic wr_sel_t resolve_write(
    input logic [MAX_NWR-1:0]            en,
    input logic [MAX_NWR*MAX_ADDR_W-1:0] addrs,
    input logic [MAX_ADDR_W-1:0]         addr
  );
    wr_sel_t sel;
    sel = '0;
    for (int j = 0; j < MAX_NWR; j++) begin
      if (en[j] && (addrs[j*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
        sel.hit = 1'b1;
        sel.idx = PORT_IDX_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - selects the winning write port and its data for one address
`timescale 1ns/1ps
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NWR    = 2
) (
  input  logic [NWR-1:0]        i_en,
  input  logic [NWR*ADDR_W-1:0] i_wr_addr,
  input  logic [NWR*DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  o_hit,
  output logic [DATA_W-1:0]     o_data
);

  logic [MAX_NWR-1:0]            w_en_pad;
  logic [MAX_NWR*MAX_ADDR_W-1:0] w_addr_pad;
  logic [MAX_ADDR_W-1:0]         w_key;
  wr_sel_t                       w_sel;

  // Widen the port vectors to the resolver's fixed shape and resolve the winner.
  always_comb begin
    w_en_pad   = '0;
    w_addr_pad = '0;
    w_key      = MAX_ADDR_W'(i_addr);
    for (int j = 0; j < NWR; j++) begin
      w_en_pad[j] = i_en[j];
      w_addr_pad[j*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(i_wr_addr[j*ADDR_W +: ADDR_W]);
    end
    w_sel = resolve_write(w_en_pad, w_addr_pad, w_key);
  end

  // Route the winning port's data out; zero when nothing hits.
  always_comb begin
    o_hit  = w_sel.hit;
    o_data = '0;
    for (int j = 0; j < NWR; j++) begin
      if (w_sel.hit && (w_sel.idx == PORT_IDX_W'(j))) begin
        o_data = i_wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-port register file with bypass and busy scoreboard
`timescale 1ns/1ps
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*ADDR_W-1:0]   wr_addr,
  input  logic [NWR*DATA_W-1:0]   wr_data,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic [(2**ADDR_W)-1:0]  busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  // Reset masks every write enable, which suppresses both storage updates and bypass.
  logic [NWR-1:0]    w_wr_en;
  logic [DATA_W-1:0] w_mem [NREGS];
  logic [NREGS-1:0]  w_busy;

  assign w_wr_en  = rst ? '0 : wr_en;
  assign busy_vec = w_busy;

  for (genvar k = 0; k < NREGS; k++) begin : g_row
    // Register 0 is hard-wired when the zero register is enabled.
    localparam bit FIXED = ZERO_REG && (k == 0);

    logic              w_hit;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_row;
    logic              r_busy;

    regfile_wr_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWR    (NWR)
    ) u_arb (
      .i_en      (w_wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_addr    (ADDR_W'(k)),
      .o_hit     (w_hit),
      .o_data    (w_data)
    );

    // Storage row: cleared on reset, loaded with the winning write port's data.
    always_ff @(posedge clk) begin
      if (rst || FIXED) begin
        r_row <= '0;
      end else if (w_hit) begin
        r_row <= w_data;
      end
    end

    // Busy bit: a reservation beats a same-cycle write since it names the newer producer.
    always_ff @(posedge clk) begin
      if (rst || FIXED) begin
        r_busy <= 1'b0;
      end else if (rsv_en && (rsv_addr == ADDR_W'(k))) begin
        r_busy <= 1'b1;
      end else if (w_hit) begin
        r_busy <= 1'b0;
      end
    end

    assign w_mem[k]  = r_row;
    assign w_busy[k] = r_busy;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;
    logic [DATA_W-1:0] w_bdata;
    logic              w_is_zero;
    logic              w_fwd;

    assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_wr_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWR    (NWR)
    ) u_arb (
      .i_en      (w_wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_addr    (w_ra),
      .o_hit     (w_hit),
      .o_data    (w_bdata)
    );

    assign w_is_zero = ZERO_REG && (w_ra == '0);
    assign w_fwd     = BYPASS && w_hit;

    assign rd_data[i*DATA_W +: DATA_W] = w_is_zero ? '0 :
                                         w_fwd     ? w_bdata : w_mem[w_ra];
    assign rd_busy[i] = !w_is_zero && w_busy[w_ra] && !w_fwd;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport
`timescale 1ns/1ps
module tb_regfile_multiport;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int NREGS = 16;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*DW-1:0]   wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NREGS-1:0]    busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_mem  [NREGS];
  logic          m_busy [NREGS];

  regfile_multiport #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference read: zero register, then newest same-cycle writer, then stored value.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!rst) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) return wr_data[j*DW +: DW];
      end
    end
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (!rst) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b0;
      end
    end
    return m_busy[a];
  endfunction

  task automatic check_model();
    logic [NREGS-1:0] e;
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("rd_data%0d", i), 32'(rd_data[i*DW +: DW]), 32'(exp_data(rd_addr[i*AW +: AW])));
      check($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(exp_busy(rd_addr[i*AW +: AW])));
    end
    for (int k = 0; k < NREGS; k++) e[k] = m_busy[k];
    check("busy_vec", 32'(busy_vec), 32'(e));
  endtask

  // Apply one clock edge to the model: writes in port order, then the reservation.
  task automatic update_model();
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        m_mem[k]  = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          m_mem[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic cyc_check();
    @(negedge clk);
    check_model();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; rsv_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    for (int k = 0; k < NREGS; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
    cyc_end();

    // Reset state
    idle(); rd_addr = {4'd5, 4'd3};
    cyc_check();
    check("rst_rd0", 32'(rd_data[15:0]), 32'h0);
    check("rst_rd1", 32'(rd_data[31:16]), 32'h0);
    check("rst_busy", 32'(busy_vec), 32'h0);
    cyc_end();

    // Bypass then storage
    wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_data = {16'h0, 16'hBEEF}; rd_addr = {4'd0, 4'd3};
    cyc_check();
    check("bypass_beef", 32'(rd_data[15:0]), 32'hBEEF);
    cyc_end();
    idle();
    cyc_check();
    check("stored_beef", 32'(rd_data[15:0]), 32'hBEEF);
    cyc_end();

    // No bypass without enable
    wr_en = 2'b01; wr_addr = {4'd0, 4'd5}; wr_data = {16'h0, 16'h1111};
    cyc_check();
    cyc_end();
    idle(); wr_addr = {4'd5, 4'd5}; wr_data = {16'h2222, 16'h2222}; rd_addr = {4'd5, 4'd5};
    cyc_check();
    check("no_en_no_bypass", 32'(rd_data[15:0]), 32'h1111);
    cyc_end();

    // Same-address collision: higher port wins
    wr_en = 2'b11; wr_addr = {4'd7, 4'd7}; wr_data = {16'h5555, 16'hAAAA}; rd_addr = {4'd7, 4'd7};
    cyc_check();
    check("collide_bypass", 32'(rd_data[31:16]), 32'h5555);
    cyc_end();
    idle();
    cyc_check();
    check("collide_stored", 32'(rd_data[15:0]), 32'h5555);
    cyc_end();

    // Zero register ignores writes and reservations
    wr_en = 2'b01; wr_addr = {4'd0, 4'd0}; wr_data = {16'h0, 16'hFFFF};
    rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr = {4'd0, 4'd0};
    cyc_check();
    check("zero_rd", 32'(rd_data[15:0]), 32'h0);
    check("zero_rdbusy", 32'(rd_busy[0]), 32'h0);
    cyc_end();
    idle();
    cyc_check();
    check("zero_busyvec", 32'(busy_vec[0]), 32'h0);
    check("zero_after", 32'(rd_data[15:0]), 32'h0);
    cyc_end();

    // Reservation, release by write, and write+reserve collision
    rsv_en = 1'b1; rsv_addr = 4'd4; rd_addr = {4'd4, 4'd4};
    cyc_check();
    cyc_end();
    idle();
    cyc_check();
    check("rsv_rdbusy", 32'(rd_busy[0]), 32'h1);
    check("rsv_busyvec", 32'(busy_vec[4]), 32'h1);
    cyc_end();
    wr_en = 2'b01; wr_addr = {4'd0, 4'd4}; wr_data = {16'h0, 16'h0042};
    cyc_check();
    check("release_busy", 32'(rd_busy[0]), 32'h0);
    check("release_data", 32'(rd_data[15:0]), 32'h0042);
    cyc_end();
    wr_en = 2'b01; wr_addr = {4'd0, 4'd4}; wr_data = {16'h0, 16'h0099}; rsv_en = 1'b1; rsv_addr = 4'd4;
    cyc_check();
    cyc_end();
    idle();
    cyc_check();
    check("wr_rsv_busy", 32'(busy_vec[4]), 32'h1);
    check("wr_rsv_data", 32'(rd_data[15:0]), 32'h0099);
    cyc_end();

    // Fill, reserve, then reset with a concurrent write
    for (int k = 1; k <= 15; k += 2) begin
      wr_en = (k + 1 <= 15) ? 2'b11 : 2'b01;
      wr_addr = {AW'(k + 1), AW'(k)};
      wr_data = {16'((k + 1) * 257 + 1), 16'(k * 257 + 1)};
      cyc_check();
      cyc_end();
    end
    idle(); rsv_en = 1'b1; rsv_addr = 4'd2;
    cyc_check();
    cyc_end();
    rst = 1'b1; rsv_en = 1'b0; wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = {16'h0, 16'h1234};
    rd_addr = {4'd2, 4'd9};
    cyc_check();
    check("rst_no_bypass", 32'(rd_data[15:0]), 32'(16'(9 * 257 + 1)));
    cyc_end();
    idle();
    for (int a = 0; a < NREGS; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      cyc_check();
      check("post_rst_rd0", 32'(rd_data[15:0]), 32'h0);
      check("post_rst_rd1", 32'(rd_data[31:16]), 32'h0);
      check("post_rst_busy", 32'(busy_vec), 32'h0);
      cyc_end();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {rand_addr(), rand_addr()};
      wr_data = $urandom();
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = rand_addr();
      rd_addr = {rand_addr(), rand_addr()};
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr[2*AW-1:AW];
      cyc_check();
      cyc_end();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
